// File: rtl/chip8_fetch_decode.sv
// chip8_fetch_decode
//    Fetches 16-bit CHIP-8 instructions, big-endian, over a byte-wide memory
//    read port and presents them decoded behind a valid/ready handshake.
//    A byte read issued in one cycle returns its data in the next cycle.
//
// Ports
//    clk, reset_n                 clock, asynchronous active-low reset
//    mem_addr, mem_rd, mem_rdata  byte read port, data valid one cycle after mem_rd
//    pc_load, pc_load_addr        fetch redirect from execute; wins in every state
//    dec_valid, dec_ready         decoded-instruction handshake
//    opcode, pc                   raw instruction and the address it came from
//    op_main, op_sub, x, y, n,
//    nn, nnn                      opcode fields
//    alu_op, alu_switchxy         8XYn ALU decode
//    jump, illegal                control-flow and illegal-opcode flags
//    schip                        SUPER-CHIP opcode flag (CHIP8_SCHIP_EN only)
//
// Build option
//    CHIP8_SCHIP_EN  accept the SUPER-CHIP extensions 00Cn, 00FB-00FF, FX30,
//                    FX75 and FX85 as legal and add the schip output port.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_HI    | read high byte at fpc
// S_LO    | capture high byte, read low byte at fpc+1
// S_CAP   | capture low byte, register decoded outputs
// S_VALID | present instruction; dec_ready advances fpc by 2

module chip8_fetch_decode #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned START_PC = 12'h200
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_addr,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [15:0]       opcode,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        op_main,
   output logic [3:0]        op_sub,
   output logic [3:0]        x,
   output logic [3:0]        y,
   output logic [3:0]        n,
   output logic [7:0]        nn,
   output logic [11:0]       nnn,
   output logic [2:0]        alu_op,
   output logic              alu_switchxy,
   output logic              jump,
`ifdef CHIP8_SCHIP_EN
   output logic              schip,
`endif
   output logic              illegal
);

   localparam logic [ADDR_W-1:0] START_FPC = ADDR_W'(START_PC);

   typedef enum logic [1:0] {S_HI, S_LO, S_CAP, S_VALID} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] fpc_p1;
   logic [7:0]        op_hi;
   logic [15:0]       cap_op;

   logic [2:0]        d_alu_op;
   logic              d_switchxy;
   logic              d_jump;
   logic              d_illegal;
`ifdef CHIP8_SCHIP_EN
   logic              d_schip;
`endif

   assign fpc_p1 = fpc + ADDR_W'(1);
   assign cap_op = {op_hi, mem_rdata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_HI;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_HI:    state_nxt = S_LO;
         S_LO:    state_nxt = S_CAP;
         S_CAP:   state_nxt = S_VALID;
         S_VALID: if (dec_ready) state_nxt = S_HI;
         default: state_nxt = S_HI;
      endcase
      if (pc_load) state_nxt = S_HI;
   end

   // Reset parks the FSM in S_HI; gating mem_rd with reset_n keeps the read
   // quiet while held, yet issues the START_PC read in the very first cycle
   // after release so the first instruction keeps its 3-cycle latency.
   always_comb begin
      mem_rd    = 1'b0;
      mem_addr  = fpc;
      dec_valid = 1'b0;
      case (state)
         S_HI:    mem_rd = reset_n;
         S_LO: begin
            mem_rd   = reset_n;
            mem_addr = fpc_p1;
         end
         S_VALID: dec_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            fpc <= START_FPC;
      else if (pc_load)                        fpc <= pc_load_addr;
      else if (state == S_VALID && dec_ready)  fpc <= fpc + ADDR_W'(2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            op_hi <= 8'h00;
      else if (state == S_LO)  op_hi <= mem_rdata;
   end

   always_comb begin
      d_alu_op   = 3'd0;
      d_switchxy = 1'b0;
      d_jump     = 1'b0;
      d_illegal  = 1'b0;
`ifdef CHIP8_SCHIP_EN
      d_schip    = 1'b0;
`endif
      case (cap_op[15:12])
         4'h0: begin
            d_illegal = !(cap_op[11:0] == 12'h0E0 || cap_op[11:0] == 12'h0EE);
            d_jump    = (cap_op[11:0] == 12'h0EE);
`ifdef CHIP8_SCHIP_EN
            if (cap_op[11:4] == 8'h0C || cap_op[11:0] inside {[12'h0FB:12'h0FF]}) begin
               d_illegal = 1'b0;
               d_schip   = 1'b1;
               d_jump    = (cap_op[11:0] == 12'h0FD);
            end
`endif
         end
         4'h1, 4'h2, 4'hB: d_jump = 1'b1;
         4'h5, 4'h9:       d_illegal = (cap_op[3:0] != 4'h0);
         4'h8: begin
            d_alu_op   = cap_op[2:0];
            d_switchxy = (cap_op[3:0] == 4'h7);
            // n = 8..D or F; E (shift left) is the only legal n above 7
            d_illegal  = cap_op[3] && (cap_op[3:0] != 4'hE);
         end
         4'hE: d_illegal = !(cap_op[7:0] inside {8'h9E, 8'hA1});
         4'hF: begin
            d_illegal = !(cap_op[7:0] inside {8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E,
                                              8'h29, 8'h33, 8'h55, 8'h65});
`ifdef CHIP8_SCHIP_EN
            if (cap_op[7:0] inside {8'h30, 8'h75, 8'h85}) begin
               d_illegal = 1'b0;
               d_schip   = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   // A redirect arriving in S_CAP drops the half-fetched instruction, so the
   // presented outputs keep the previous instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opcode       <= 16'h0000;
         pc           <= '0;
         alu_op       <= 3'd0;
         alu_switchxy <= 1'b0;
         jump         <= 1'b0;
         illegal      <= 1'b0;
`ifdef CHIP8_SCHIP_EN
         schip        <= 1'b0;
`endif
      end else if (state == S_CAP && !pc_load) begin
         opcode       <= cap_op;
         pc           <= fpc;
         alu_op       <= d_alu_op;
         alu_switchxy <= d_switchxy;
         jump         <= d_jump;
         illegal      <= d_illegal;
`ifdef CHIP8_SCHIP_EN
         schip        <= d_schip;
`endif
      end
   end

   assign op_main = opcode[15:12];
   assign x       = opcode[11:8];
   assign y       = opcode[7:4];
   assign n       = opcode[3:0];
   assign op_sub  = opcode[3:0];
   assign nn      = opcode[7:0];
   assign nnn     = opcode[11:0];

endmodule

// File: tb/tb_chip8_fetch_decode.sv
// tb_chip8_fetch_decode
//    Drives chip8_fetch_decode from a byte memory and compares every cycle
//    against a transaction-level model: a fetch started at address A shows
//    up decoded three cycles later unless a redirect intervenes, and the
//    presented instruction stays put until it is accepted.

module tb_chip8_fetch_decode;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        pc_load;
   logic [11:0] pc_load_addr;
   logic        dec_valid;
   logic        dec_ready;
   logic [15:0] opcode;
   logic [11:0] pc;
   logic [3:0]  op_main, op_sub, x, y, n;
   logic [7:0]  nn;
   logic [11:0] nnn;
   logic [2:0]  alu_op;
   logic        alu_switchxy;
   logic        jump;
   logic        illegal;
`ifdef CHIP8_SCHIP_EN
   logic        schip;
`endif

   chip8_fetch_decode dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_rdata    (mem_rdata),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .opcode       (opcode),
      .pc           (pc),
      .op_main      (op_main),
      .op_sub       (op_sub),
      .x            (x),
      .y            (y),
      .n            (n),
      .nn           (nn),
      .nnn          (nnn),
      .alu_op       (alu_op),
      .alu_switchxy (alu_switchxy),
      .jump         (jump),
`ifdef CHIP8_SCHIP_EN
      .schip        (schip),
`endif
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:4095];

   // Read data only meaningful the cycle after a read; junk otherwise.
   always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [11:0] m_addr;
   int          m_age;
   logic [15:0] e_op;
   logic [11:0] e_pc;
   logic [6:0]  e_flags;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // {schip, illegal, jump, alu_switchxy, alu_op[2:0]} from the opcode rules
   function automatic logic [6:0] ref_dec(input logic [15:0] op);
      int m, lo, b;
      bit ill, jmp, sch;
      m   = op / 4096;
      lo  = op % 16;
      b   = op % 256;
      ill = 1'b0;
      sch = 1'b0;
      jmp = (m == 1 || m == 2 || m == 11 || op == 16'h00EE);
      if (m == 0)           ill = (op != 16'h00E0 && op != 16'h00EE);
      if (m == 5 || m == 9) ill = (lo != 0);
      if (m == 8)           ill = (lo >= 8 && lo <= 13) || lo == 15;
      if (m == 14)          ill = !(b == 'h9E || b == 'hA1);
      if (m == 15)          ill = !(b inside {'h07, 'h0A, 'h15, 'h18, 'h1E, 'h29, 'h33, 'h55, 'h65});
`ifdef CHIP8_SCHIP_EN
      if ((op >= 16'h00C0 && op <= 16'h00CF) || (op >= 16'h00FB && op <= 16'h00FF) ||
          (m == 15 && b inside {'h30, 'h75, 'h85})) begin
         ill = 1'b0;
         sch = 1'b1;
         if (op == 16'h00FD) jmp = 1'b1;
      end
`endif
      return {sch, ill, jmp, (m == 8 && lo == 7), (m == 8) ? 3'(lo % 8) : 3'd0};
   endfunction

   function automatic logic [15:0] pick_op();
      logic [15:0] r;
      logic [7:0]  fl [0:11];
      r  = 16'($urandom);
      fl = '{8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E, 8'h29, 8'h33, 8'h55, 8'h65, 8'h30, 8'h75, 8'h85};
      case ($urandom_range(0, 10))
         0:       return 16'h00E0;
         1:       return 16'h00EE;
         2:       return 16'h00C0 + 16'(r % 16);
         3:       return 16'h00FB + 16'($urandom_range(0, 4));
         4:       return {4'h8, r[11:0]};
         5:       return {4'h5, r[11:0]};
         6:       return {4'h9, r[11:0]};
         7:       return {4'hE, r[11:8], ($urandom_range(0, 2) == 0) ? r[7:0] : (r[0] ? 8'h9E : 8'hA1)};
         8:       return {4'hF, r[11:8], ($urandom_range(0, 3) == 0) ? r[7:0] : fl[$urandom_range(0, 11)]};
         9:       return {4'hB, r[11:0]};
         default: return r;
      endcase
   endfunction

   task automatic check_outputs();
      check_val("dec_valid", dec_valid, m_age >= 3);
      check_val("mem_rd", mem_rd, m_age < 2);
      if (m_age == 0) check_val("mem_addr_hi", mem_addr, m_addr);
      if (m_age == 1) check_val("mem_addr_lo", mem_addr, 12'(m_addr + 12'd1));
      check_val("opcode", opcode, e_op);
      check_val("pc", pc, e_pc);
      check_val("op_main", op_main, e_op / 4096);
      check_val("x", x, (e_op / 256) % 16);
      check_val("y", y, (e_op / 16) % 16);
      check_val("n", n, e_op % 16);
      check_val("op_sub", op_sub, e_op % 16);
      check_val("nn", nn, e_op % 256);
      check_val("nnn", nnn, e_op % 4096);
      check_val("alu_op", alu_op, e_flags[2:0]);
      check_val("alu_switchxy", alu_switchxy, e_flags[3]);
      check_val("jump", jump, e_flags[4]);
      check_val("illegal", illegal, e_flags[5]);
`ifdef CHIP8_SCHIP_EN
      check_val("schip", schip, e_flags[6]);
`endif
   endtask

   // One clock: apply inputs, advance the model by the same inputs, compare.
   task automatic cycle(input logic rdy, input logic ld, input logic [11:0] la);
      dec_ready    = rdy;
      pc_load      = ld;
      pc_load_addr = la;
      @(posedge clk);
      #1;
      if (ld) begin
         m_addr = la;
         m_age  = 0;
      end else if (m_age >= 3) begin
         if (rdy) begin
            m_addr = 12'(m_addr + 12'd2);
            m_age  = 0;
         end
      end else begin
         m_age++;
         if (m_age == 3) begin
            e_op    = {mem[m_addr], mem[12'(m_addr + 12'd1)]};
            e_pc    = m_addr;
            e_flags = ref_dec(e_op);
         end
      end
      check_outputs();
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 8 && !dec_valid; i++) cycle(1'b0, 1'b0, 12'h000);
      check_val(tag, dec_valid, 1);
   endtask

   task automatic model_reset();
      m_addr  = 12'h200;
      m_age   = 0;
      e_op    = 16'h0000;
      e_pc    = 12'h000;
      e_flags = 7'd0;
   endtask

   initial begin
      int   r;
      logic ld, rdy;
      logic [11:0] la;

      reset_n      = 1'b0;
      dec_ready    = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = 12'h000;
      for (int i = 0; i < 4096; i += 2) {mem[i], mem[i+1]} = pick_op();
      {mem[12'h200], mem[12'h201]} = 16'h1ABC;
      {mem[12'h202], mem[12'h203]} = 16'h8AB7;
      {mem[12'h204], mem[12'h205]} = 16'h8AB8;
      {mem[12'h206], mem[12'h207]} = 16'h00FF;
      model_reset();

      #12;
      check_val("rst_mem_rd", mem_rd, 0);
      check_val("rst_dec_valid", dec_valid, 0);
      check_val("rst_opcode", opcode, 0);
      check_val("rst_illegal", illegal, 0);

      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_outputs();
      check_val("first_addr", mem_addr, 12'h200);
      check_val("first_rd", mem_rd, 1);
      cycle(1'b0, 1'b0, 12'h000);
      check_val("second_addr", mem_addr, 12'h201);
      cycle(1'b0, 1'b0, 12'h000);
      check_val("c2_not_valid", dec_valid, 0);
      cycle(1'b0, 1'b0, 12'h000);
      check_val("valid_at_c3", dec_valid, 1);
      check_val("first_opcode", opcode, 16'h1ABC);
      check_val("first_nnn", nnn, 12'hABC);
      check_val("first_jump", jump, 1);
      check_val("first_pc", pc, 12'h200);

      repeat (10) cycle(1'b0, 1'b0, 12'h000);
      check_val("stall_valid", dec_valid, 1);
      check_val("stall_opcode", opcode, 16'h1ABC);
      cycle(1'b1, 1'b0, 12'h000);
      check_val("after_stall_addr", mem_addr, 12'h202);

      wait_valid("valid_8ab7");
      check_val("8ab7_alu_op", alu_op, 7);
      check_val("8ab7_switch", alu_switchxy, 1);
      check_val("8ab7_x", x, 4'hA);
      check_val("8ab7_y", y, 4'hB);
      check_val("8ab7_illegal", illegal, 0);
      cycle(1'b1, 1'b0, 12'h000);
      wait_valid("valid_8ab8");
      check_val("8ab8_illegal", illegal, 1);
      cycle(1'b1, 1'b0, 12'h000);
      wait_valid("valid_00ff");
`ifdef CHIP8_SCHIP_EN
      check_val("00ff_illegal", illegal, 0);
      check_val("00ff_schip", schip, 1);
`else
      check_val("00ff_illegal", illegal, 1);
`endif

      cycle(1'b1, 1'b0, 12'h000);
      cycle(1'b0, 1'b0, 12'h000);
      cycle(1'b0, 1'b1, 12'h3A0);
      check_val("redirect_addr", mem_addr, 12'h3A0);
      check_val("redirect_valid", dec_valid, 0);
      wait_valid("valid_3a0");
      check_val("redirect_pc", pc, 12'h3A0);

      cycle(1'b1, 1'b1, 12'hFFF);
      check_val("wrap_hi_addr", mem_addr, 12'hFFF);
      cycle(1'b0, 1'b0, 12'h000);
      check_val("wrap_lo_addr", mem_addr, 12'h000);
      wait_valid("valid_fff");
      check_val("wrap_pc", pc, 12'hFFF);
      cycle(1'b1, 1'b0, 12'h000);
      check_val("wrap_next_addr", mem_addr, 12'h001);

      repeat (3000) begin
         r   = $urandom_range(0, 99);
         ld  = (r < 6);
         la  = (r == 0) ? 12'hFFF : 12'($urandom);
         rdy = 1'($urandom_range(0, 1));
         cycle(rdy, ld, la);
      end

      for (int i = 0; i < 8 && m_age != 1; i++) cycle(1'b1, 1'b0, 12'h000);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_val("midrst_mem_rd", mem_rd, 0);
      check_val("midrst_valid", dec_valid, 0);
      check_val("midrst_opcode", opcode, 0);
      check_val("midrst_illegal", illegal, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_outputs();
      wait_valid("valid_after_rst");
      check_val("after_rst_opcode", opcode, 16'h1ABC);
      check_val("after_rst_pc", pc, 12'h200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
